mul_operand_sequencer: RTL

//  Parametrised, handshaked operand front-end for the vector multiplier's 18x18 signed multiplier array.

---
 rtl/mul_operand_sequencer_if.sv | 41 ++++
 rtl/mul_operand_sequencer.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/mul_operand_sequencer_if.sv
// mul_operand_sequencer_if
// Handshake bundle between the vALU issue stage and the multiplier operand
// sequencer, and between the sequencer and the 18x18 multiplier array.
//   in_*  : operand set from issue (valid/ready), vs2 = in_a, vs1 = in_b
//   out_* : operand pairs to the multiplier array (valid/ready)
// Modports: slave = sequencer side, master = issue/array side.
interface mul_operand_sequencer_if #(
  parameter int LANES   = 1,
  parameter int OUT_W   = 18,
  parameter int TAG_W   = 4,
  parameter int SEW_W   = 2,
  parameter int OPSEL_W = 2
);
  localparam int DATA_W = 64 * LANES;

  logic                     in_valid;
  logic                     in_ready;
  logic [DATA_W-1:0]        in_a;
  logic [DATA_W-1:0]        in_b;
  logic [SEW_W-1:0]         in_sew;
  logic [OPSEL_W-1:0]       in_opsel;
  logic [TAG_W-1:0]         in_tag;
  logic                     out_valid;
  logic                     out_ready;
  logic [LANES*8*OUT_W-1:0] out_a;
  logic [LANES*8*OUT_W-1:0] out_b;
  logic                     out_beat;
  logic                     out_last;
  logic [SEW_W-1:0]         out_sew;
  logic [TAG_W-1:0]         out_tag;

  modport slave (
    input  in_valid, in_a, in_b, in_sew, in_opsel, in_tag, out_ready,
    output in_ready, out_valid, out_a, out_b, out_beat, out_last, out_sew, out_tag
  );

  modport master (
    output in_valid, in_a, in_b, in_sew, in_opsel, in_tag, out_ready,
    input  in_ready, out_valid, out_a, out_b, out_beat, out_last, out_sew, out_tag
  );
endinterface

// File: rtl/mul_operand_sequencer.sv
// mul_operand_sequencer
// Operand front-end for the signed 18x18 multiplier array. Slices each 64-bit
// lane of vs2/vs1 into 16-bit (or 8-bit) chunks, extends them to OUT_W and
// issues 8 operand pairs per lane per beat. SEW=64 takes two beats.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   bus (slave)     in_* operand handshake, out_* pair handshake
//   stall_cnt_o     cycles spent with out_valid & ~out_ready (saturating),
//                   present only when MUL_OPSEL_PERF_CNT_EN is defined
// Optional feature macro: MUL_OPSEL_PERF_CNT_EN
//
// state | meaning
// IDLE  | no operand set held, in_ready high
// BEAT0 | first (or only) beat presented on out_*
// BEAT1 | second beat of an SEW=64 set presented on out_*
module mul_operand_sequencer #(
  parameter int LANES   = 1,
  parameter int OUT_W   = 18,
  parameter int TAG_W   = 4,
  parameter int SEW_W   = 2,
  parameter int OPSEL_W = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  mul_operand_sequencer_if.slave bus
`ifdef MUL_OPSEL_PERF_CNT_EN
  ,
  output logic [31:0]           stall_cnt_o
`endif
);
  localparam int DATA_W = 64 * LANES;
  localparam logic [SEW_W-1:0] SEW8  = SEW_W'(0);
  localparam logic [SEW_W-1:0] SEW16 = SEW_W'(1);
  localparam logic [SEW_W-1:0] SEW32 = SEW_W'(2);
  localparam logic [SEW_W-1:0] SEW64 = SEW_W'(3);

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1} state_t;

  state_t             state_q;
  logic [DATA_W-1:0]  a_q, b_q;
  logic [SEW_W-1:0]   sew_q;
  logic               a_signed_q, b_signed_q;

  logic               in_fire, out_fire;
  logic [DATA_W-1:0]  src_a, src_b;
  logic [SEW_W-1:0]   src_sew;
  logic               src_a_s, src_b_s, src_beat1;
  logic [LANES*8*OUT_W-1:0] pa_d, pb_d;

  function automatic logic [OUT_W-1:0] ext16(input logic [15:0] v, input logic s);
    return {{(OUT_W-16){s & v[15]}}, v};
  endfunction

  function automatic logic [OUT_W-1:0] ext8(input logic [7:0] v, input logic s);
    return {{(OUT_W-8){s & v[7]}}, v};
  endfunction

  assign bus.in_ready = (state_q == IDLE) | (bus.out_valid & bus.out_ready & bus.out_last);
  assign in_fire      = bus.in_valid & bus.in_ready;
  assign out_fire     = bus.out_valid & bus.out_ready;

  // A new set always produces its first beat; otherwise the only pending
  // beat we can advance to is beat1 of the held SEW=64 set.
  assign src_a     = in_fire ? bus.in_a : a_q;
  assign src_b     = in_fire ? bus.in_b : b_q;
  assign src_sew   = in_fire ? bus.in_sew : sew_q;
  assign src_a_s   = in_fire ? (bus.in_opsel != '0) : a_signed_q;
  assign src_b_s   = in_fire ? bus.in_opsel[0] : b_signed_q;
  assign src_beat1 = ~in_fire;

  always_comb begin
    pa_d = '0;
    pb_d = '0;
    for (int l = 0; l < LANES; l++) begin
      case (src_sew)
        SEW8: begin
          for (int p = 0; p < 8; p++) begin
            pa_d[(l*8+p)*OUT_W +: OUT_W] = ext8(src_a[l*64+p*8 +: 8], src_a_s);
            pb_d[(l*8+p)*OUT_W +: OUT_W] = ext8(src_b[l*64+p*8 +: 8], src_b_s);
          end
        end
        SEW16: begin
          for (int p = 0; p < 4; p++) begin
            pa_d[(l*8+p)*OUT_W +: OUT_W] = ext16(src_a[l*64+p*16 +: 16], src_a_s);
            pb_d[(l*8+p)*OUT_W +: OUT_W] = ext16(src_b[l*64+p*16 +: 16], src_b_s);
          end
        end
        SEW32: begin
          // k[1] picks aH over aL, k[0] picks bH over bL; only H is signed.
          for (int e = 0; e < 2; e++) begin
            for (int k = 0; k < 4; k++) begin
              pa_d[(l*8+4*e+k)*OUT_W +: OUT_W] =
                ext16(src_a[l*64+(2*e+k/2)*16 +: 16], src_a_s & (k/2 == 1));
              pb_d[(l*8+4*e+k)*OUT_W +: OUT_W] =
                ext16(src_b[l*64+(2*e+k%2)*16 +: 16], src_b_s & (k%2 == 1));
            end
          end
        end
        default: begin
          // SEW64: beat0 covers b chunks 0,1; beat1 covers b chunks 2,3.
          for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 2; j++) begin
              pa_d[(l*8+2*i+j)*OUT_W +: OUT_W] =
                ext16(src_a[l*64+i*16 +: 16], src_a_s & (i == 3));
              pb_d[(l*8+2*i+j)*OUT_W +: OUT_W] =
                ext16(src_b[l*64+(src_beat1 ? j+2 : j)*16 +: 16],
                      src_b_s & src_beat1 & (j == 1));
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      a_q           <= '0;
      b_q           <= '0;
      sew_q         <= '0;
      a_signed_q    <= 1'b0;
      b_signed_q    <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_a     <= '0;
      bus.out_b     <= '0;
      bus.out_beat  <= 1'b0;
      bus.out_last  <= 1'b0;
      bus.out_sew   <= '0;
      bus.out_tag   <= '0;
    end else if (in_fire) begin
      state_q       <= BEAT0;
      a_q           <= bus.in_a;
      b_q           <= bus.in_b;
      sew_q         <= bus.in_sew;
      a_signed_q    <= src_a_s;
      b_signed_q    <= src_b_s;
      bus.out_valid <= 1'b1;
      bus.out_a     <= pa_d;
      bus.out_b     <= pb_d;
      bus.out_beat  <= 1'b0;
      bus.out_last  <= (bus.in_sew != SEW64);
      bus.out_sew   <= bus.in_sew;
      bus.out_tag   <= bus.in_tag;
    end else if (out_fire) begin
      if (!bus.out_last) begin
        state_q      <= BEAT1;
        bus.out_a    <= pa_d;
        bus.out_b    <= pb_d;
        bus.out_beat <= 1'b1;
        bus.out_last <= 1'b1;
      end else begin
        state_q       <= IDLE;
        bus.out_valid <= 1'b0;
      end
    end
  end

`ifdef MUL_OPSEL_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_o <= '0;
    end else if (bus.out_valid && !bus.out_ready && stall_cnt_o != 32'hFFFF_FFFF) begin
      stall_cnt_o <= stall_cnt_o + 32'd1;
    end
  end
`endif

endmodule
